// File: rtl/wb_master_rr.sv
// Round-robin Wishbone classic master serving NUM_CH valid/ready request channels.
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master_rr #(
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 11,
    parameter int GRANULARITY    = 8,
    parameter int NUM_CH         = 2,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_W         = WB_DATA_WIDTH / GRANULARITY
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_CH-1:0]                 req_valid_i,
    output logic [NUM_CH-1:0]                 req_ready_o,
    input  logic [NUM_CH-1:0]                 req_we_i,
    input  logic [NUM_CH*WB_ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NUM_CH*WB_DATA_WIDTH-1:0]   req_data_i,
    input  logic [NUM_CH*SEL_W-1:0]           req_sel_i,
    output logic [NUM_CH-1:0]                 done_o,
    output logic                              done_err_o,
    output logic [WB_DATA_WIDTH-1:0]          rd_data_o,
    output logic [WB_ADDR_WIDTH-1:0]          addr_o,
    output logic [WB_DATA_WIDTH-1:0]          data_o,
    input  logic [WB_DATA_WIDTH-1:0]          data_i,
    output logic [SEL_W-1:0]                  sel_o,
    output logic                              we_o,
    output logic                              cyc_o,
    output logic                              stb_o,
    input  logic                              ack_i,
    input  logic                              err_i
);

    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned NCH_U = NUM_CH;

    if (NUM_CH < 1 || NUM_CH > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("wb_master_rr: NUM_CH must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        IDLE,
        ACK_PHASE
    } state_t;

    state_t            state, state_next;
    logic [PTR_W-1:0]  ptr, owner, gnt_idx, ptr_next;
    logic              gnt_found;
    logic              bus_end;
    logic              end_err;
    logic              timeout_hit;
    int unsigned       scan_idx;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    // Held at zero while idle, so it is already clear on entry to ACK_PHASE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            to_cnt <= '0;
        end else if (state == IDLE) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign timeout_hit = (state == ACK_PHASE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Round-robin scan starting at the pointer, wrapping modulo NUM_CH.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = 0;
        for (int unsigned i = 0; i < NCH_U; i++) begin
            scan_idx = (32'(ptr) + i) % NCH_U;
            if (!gnt_found && req_valid_i[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(scan_idx);
            end
        end
    end

    assign ptr_next = (gnt_idx == PTR_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        req_ready_o = '0;
        bus_end     = 1'b0;
        end_err     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_found && !rst_i) begin
                    req_ready_o[gnt_idx] = 1'b1;
                    state_next           = ACK_PHASE;
                end
            end
            ACK_PHASE: begin
                // ack/err take priority over a timeout on the same edge.
                if (ack_i || err_i) begin
                    bus_end    = 1'b1;
                    end_err    = err_i;
                    state_next = IDLE;
                end else if (timeout_hit) begin
                    bus_end    = 1'b1;
                    end_err    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_o     <= '0;
            data_o     <= '0;
            sel_o      <= '0;
            we_o       <= 1'b0;
            cyc_o      <= 1'b0;
            stb_o      <= 1'b0;
            owner      <= '0;
            ptr        <= '0;
            done_o     <= '0;
            done_err_o <= 1'b0;
            rd_data_o  <= '0;
        end else begin
            done_o     <= '0;
            done_err_o <= 1'b0;
            if (|req_ready_o) begin
                addr_o <= req_addr_i[gnt_idx*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                data_o <= req_data_i[gnt_idx*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                sel_o  <= req_sel_i[gnt_idx*SEL_W +: SEL_W];
                we_o   <= req_we_i[gnt_idx];
                cyc_o  <= 1'b1;
                stb_o  <= 1'b1;
                owner  <= gnt_idx;
                ptr    <= ptr_next;
            end
            if (bus_end) begin
                cyc_o      <= 1'b0;
                stb_o      <= 1'b0;
                done_o     <= NUM_CH'(1) << owner;
                done_err_o <= end_err;
                if (ack_i && !err_i && !we_o) begin
                    rd_data_o <= data_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_master_rr.sv
// Scoreboard bench for wb_master_rr: directed requests push expected grants,
// bus cycles and completions; a monitor pops and compares as the DUT presents them.
module tb_wb_master_rr;

    localparam int DW  = 32;
    localparam int AW  = 11;
    localparam int SW  = 4;
    localparam int NCH = 2;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b1;
    logic [NCH-1:0]    req_valid_i, req_ready_o, req_we_i, done_o;
    logic [NCH*AW-1:0] req_addr_i;
    logic [NCH*DW-1:0] req_data_i;
    logic [NCH*SW-1:0] req_sel_i;
    logic              done_err_o, we_o, cyc_o, stb_o, ack_i, err_i;
    logic [DW-1:0]     rd_data_o, data_o, data_i;
    logic [AW-1:0]     addr_o;
    logic [SW-1:0]     sel_o;

    always #5 clk_i = ~clk_i;

    wb_master_rr #(
        .WB_DATA_WIDTH (DW),
        .WB_ADDR_WIDTH (AW),
        .GRANULARITY   (8),
        .NUM_CH        (NCH),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_sel_i(req_sel_i),
        .done_o(done_o), .done_err_o(done_err_o), .rd_data_o(rd_data_o),
        .addr_o(addr_o), .data_o(data_o), .data_i(data_i), .sel_o(sel_o),
        .we_o(we_o), .cyc_o(cyc_o), .stb_o(stb_o), .ack_i(ack_i), .err_i(err_i)
    );

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] sel;
    } req_t;

    typedef struct packed {
        logic [NCH-1:0] ch_oh;
        logic           err;
        logic [DW-1:0]  rd;
    } done_t;

    req_t  cq0[$], cq1[$], exp_bus[$];
    int    exp_gnt[$];
    done_t exp_done[$];

    int checks   = 0;
    int failures = 0;

    int            slv_delay = 1;
    bit            slv_err   = 1'b0;
    bit            slv_noack = 1'b0;
    logic [DW-1:0] slv_rdata = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic req_t mk_req(input logic we, input logic [AW-1:0] a,
                                    input logic [DW-1:0] d, input logic [SW-1:0] s);
        mk_req = {we, a, d, s};
    endfunction

    function automatic done_t mk_done(input logic [NCH-1:0] c, input logic e, input logic [DW-1:0] r);
        mk_done = {c, e, r};
    endfunction

    // Call in the order the arbiter is expected to grant.
    task automatic push_req(input int c, input req_t r, input done_t d, input bit has_done);
        exp_gnt.push_back(c);
        exp_bus.push_back(r);
        if (has_done) exp_done.push_back(d);
        if (c == 0) cq0.push_back(r);
        else        cq1.push_back(r);
    endtask

    function automatic int pending();
        return cq0.size() + cq1.size() + exp_gnt.size() + exp_bus.size() + exp_done.size();
    endfunction

    task automatic wait_drain(input int maxc);
        for (int i = 0; i < maxc && pending() != 0; i++) @(negedge clk_i);
        chk("drain_pending", 64'(pending()), 64'd0);
        repeat (2) @(negedge clk_i);
    endtask

    // Client: presents the head of each channel queue, pops it after a handshake edge.
    initial begin : client
        bit hs0, hs1;
        req_valid_i = '0;
        req_we_i    = '0;
        req_addr_i  = '0;
        req_data_i  = '0;
        req_sel_i   = '0;
        forever begin
            @(negedge clk_i);
            hs0 = req_valid_i[0] && req_ready_o[0];
            hs1 = req_valid_i[1] && req_ready_o[1];
            @(posedge clk_i);
            #1;
            if (hs0 && cq0.size() > 0) cq0.delete(0);
            if (hs1 && cq1.size() > 0) cq1.delete(0);
            req_valid_i[0] = (cq0.size() > 0);
            if (cq0.size() > 0) begin
                req_we_i[0]        = cq0[0].we;
                req_addr_i[0+:AW]  = cq0[0].addr;
                req_data_i[0+:DW]  = cq0[0].data;
                req_sel_i[0+:SW]   = cq0[0].sel;
            end
            req_valid_i[1] = (cq1.size() > 0);
            if (cq1.size() > 0) begin
                req_we_i[1]        = cq1[0].we;
                req_addr_i[AW+:AW] = cq1[0].addr;
                req_data_i[DW+:DW] = cq1[0].data;
                req_sel_i[SW+:SW]  = cq1[0].sel;
            end
        end
    end

    // Slave: answers slv_delay cycles into a strobe, one-cycle ack (plus err when slv_err).
    initial begin : slave
        int cnt;
        cnt    = 0;
        ack_i  = 1'b0;
        err_i  = 1'b0;
        data_i = '0;
        forever begin
            @(negedge clk_i);
            #1;
            if (ack_i || err_i) begin
                ack_i  = 1'b0;
                err_i  = 1'b0;
                data_i = '0;
                cnt    = 0;
            end else if (stb_o) begin
                cnt++;
                if (!slv_noack && cnt >= slv_delay) begin
                    ack_i  = 1'b1;
                    err_i  = slv_err;
                    data_i = slv_rdata;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin : monitor
        logic  prev_stb;
        int    g;
        req_t  b;
        done_t d;
        prev_stb = 1'b0;
        forever begin
            @(negedge clk_i);
            if (req_ready_o != '0) begin
                if (exp_gnt.size() == 0) chk("grant_unexpected", 64'(req_ready_o), 64'd0);
                else begin
                    g = exp_gnt.pop_front();
                    chk("grant", 64'(req_ready_o), 64'(NCH'(1) << g));
                end
            end
            if (stb_o && !prev_stb) begin
                if (exp_bus.size() == 0) chk("bus_unexpected", 64'd1, 64'd0);
                else begin
                    b = exp_bus.pop_front();
                    chk("bus_addr", 64'(addr_o), 64'(b.addr));
                    chk("bus_data", 64'(data_o), 64'(b.data));
                    chk("bus_sel",  64'(sel_o),  64'(b.sel));
                    chk("bus_we",   64'(we_o),   64'(b.we));
                    chk("bus_cyc",  64'(cyc_o),  64'd1);
                end
            end
            if ((ack_i || err_i) && prev_stb) chk("done_latency", 64'(done_o != '0), 64'd1);
            if (done_o != '0) begin
                if (exp_done.size() == 0) chk("done_unexpected", 64'(done_o), 64'd0);
                else begin
                    d = exp_done.pop_front();
                    chk("done_ch",  64'(done_o),     64'(d.ch_oh));
                    chk("done_err", 64'(done_err_o), 64'(d.err));
                    chk("rd_data",  64'(rd_data_o),  64'(d.rd));
                    chk("stb_low_at_done", 64'(stb_o), 64'd0);
                end
            end
            prev_stb = stb_o;
        end
    end

    initial begin : stim
        int n;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_ctrl", 64'({cyc_o, stb_o, we_o, done_o, done_err_o, req_ready_o, sel_o}), 64'd0);
        chk("rst_bus",  64'({addr_o, data_o}), 64'd0);
        chk("rst_rd",   64'(rd_data_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        // single write on ch0, ack two cycles into the strobe
        slv_delay = 2;
        push_req(0, mk_req(1'b1, 11'h012, 32'h0000_1234, 4'b0011), mk_done(2'b01, 1'b0, 32'h0), 1'b1);
        wait_drain(50);

        // single read on ch1
        slv_delay = 1;
        slv_rdata = 32'hDEAD_BEEF;
        push_req(1, mk_req(1'b0, 11'h405, 32'h0, 4'hF), mk_done(2'b10, 1'b0, 32'hDEAD_BEEF), 1'b1);
        wait_drain(50);

        // contention: pointer back at 0, expect 0,1,0,1
        slv_rdata = 32'h1111_2222;
        push_req(0, mk_req(1'b1, 11'h100, 32'h0000_00A0, 4'hF),    mk_done(2'b01, 1'b0, 32'hDEAD_BEEF), 1'b1);
        push_req(1, mk_req(1'b1, 11'h200, 32'h0000_00B1, 4'b1100), mk_done(2'b10, 1'b0, 32'hDEAD_BEEF), 1'b1);
        push_req(0, mk_req(1'b0, 11'h101, 32'h0,         4'hF),    mk_done(2'b01, 1'b0, 32'h1111_2222), 1'b1);
        push_req(1, mk_req(1'b1, 11'h201, 32'h0000_00B2, 4'b0001), mk_done(2'b10, 1'b0, 32'h1111_2222), 1'b1);
        wait_drain(100);

        // err with ack on a read: flagged, read data untouched
        slv_err   = 1'b1;
        slv_rdata = 32'h5555_AAAA;
        push_req(0, mk_req(1'b0, 11'h033, 32'h0, 4'hF), mk_done(2'b01, 1'b1, 32'h1111_2222), 1'b1);
        wait_drain(50);
        slv_err = 1'b0;

        slv_noack = 1'b1;
`ifdef WB_MASTER_TIMEOUT_EN
        push_req(0, mk_req(1'b0, 11'h7FF, 32'h0, 4'hF), mk_done(2'b01, 1'b1, 32'h1111_2222), 1'b1);
        for (int i = 0; i < 20 && !stb_o; i++) @(negedge clk_i);
        chk("timeout_stb_start", 64'(stb_o), 64'd1);
        n = 0;
        while (stb_o && n < 200) begin
            n++;
            @(negedge clk_i);
        end
        chk("timeout_stb_cycles", 64'(n), 64'd8);
        wait_drain(50);
        push_req(0, mk_req(1'b1, 11'h055, 32'h0000_ABCD, 4'b0011), mk_done(2'b01, 1'b0, 32'h0), 1'b0);
        for (int i = 0; i < 20 && !stb_o; i++) @(negedge clk_i);
        chk("rst_test_stb_start", 64'(stb_o), 64'd1);
        repeat (3) @(negedge clk_i);
`else
        push_req(0, mk_req(1'b0, 11'h7FF, 32'h0, 4'hF), mk_done(2'b01, 1'b1, 32'h0), 1'b0);
        for (int i = 0; i < 20 && !stb_o; i++) @(negedge clk_i);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (stb_o) n++;
            @(negedge clk_i);
        end
        chk("stall_stb_cycles", 64'(n), 64'd100);
`endif

        // asynchronous reset in the middle of ACK_PHASE, away from any clock edge
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        #1;
        chk("rst_async_cyc_stb", 64'({cyc_o, stb_o}), 64'd0);
        chk("rst_async_done", 64'(done_o), 64'd0);
        repeat (2) @(negedge clk_i);
        rst_i     = 1'b0;
        slv_noack = 1'b0;
        chk("rst_async_rd", 64'(rd_data_o), 64'd0);
        wait_drain(10);

        // pointer restarts at 0 after reset
        push_req(0, mk_req(1'b1, 11'h0AA, 32'h0000_0077, 4'hF), mk_done(2'b01, 1'b0, 32'h0), 1'b1);
        push_req(1, mk_req(1'b1, 11'h0BB, 32'h0000_0088, 4'h1), mk_done(2'b10, 1'b0, 32'h0), 1'b1);
        wait_drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
